// File: rtl/reg_abi_pkg.sv
// Shared tables and helpers for the RISC-V ABI register namer.
// Holds the 32-entry name/length tables and the abi_name/abi_len lookups.
package reg_abi_pkg;

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NAME_W = 32;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned NUM_REGS = 32;

    // Names are right-justified ASCII: first character in the most
    // significant used byte, unused leading bytes are 0x00.
    localparam logic [NAME_W-1:0] FP_NAME = 32'h0000_6670;

    localparam logic [NAME_W-1:0] ABI_NAMES [NUM_REGS] = '{
        32'h7A65_726F, // x0  zero
        32'h0000_7261, // x1  ra
        32'h0000_7370, // x2  sp
        32'h0000_6770, // x3  gp
        32'h0000_7470, // x4  tp
        32'h0000_7430, // x5  t0
        32'h0000_7431, // x6  t1
        32'h0000_7432, // x7  t2
        32'h0000_7330, // x8  s0
        32'h0000_7331, // x9  s1
        32'h0000_6130, // x10 a0
        32'h0000_6131, // x11 a1
        32'h0000_6132, // x12 a2
        32'h0000_6133, // x13 a3
        32'h0000_6134, // x14 a4
        32'h0000_6135, // x15 a5
        32'h0000_6136, // x16 a6
        32'h0000_6137, // x17 a7
        32'h0000_7332, // x18 s2
        32'h0000_7333, // x19 s3
        32'h0000_7334, // x20 s4
        32'h0000_7335, // x21 s5
        32'h0000_7336, // x22 s6
        32'h0000_7337, // x23 s7
        32'h0000_7338, // x24 s8
        32'h0000_7339, // x25 s9
        32'h0073_3130, // x26 s10
        32'h0073_3131, // x27 s11
        32'h0000_7433, // x28 t3
        32'h0000_7434, // x29 t4
        32'h0000_7435, // x30 t5
        32'h0000_7436  // x31 t6
    };

    localparam logic [LEN_W-1:0] ABI_LENS [NUM_REGS] = '{
        3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2
    };

    // x8 doubles as the frame pointer; the alias only changes the name,
    // "fp" has the same length as "s0".
    function automatic logic [NAME_W-1:0] abi_name(
        input logic [IDX_W-1:0] idx,
        input logic             fp_alias
    );
        logic [NAME_W-1:0] name;
        name = ABI_NAMES[idx];
        if (fp_alias && (idx == 5'd8)) begin
            name = FP_NAME;
        end
        return name;
    endfunction

    function automatic logic [LEN_W-1:0] abi_len(
        input logic [IDX_W-1:0] idx
    );
        return ABI_LENS[idx];
    endfunction

endpackage

// File: rtl/reg_abi_lut.sv
// Combinational single-lane register index to ABI name lookup.
// Ports: idx (5-bit index) -> name (ASCII), len (chars), is_zero (x0).
module reg_abi_lut
    import reg_abi_pkg::*;
#(
    parameter bit FP_ALIAS = 1'b0
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [NAME_W-1:0] name,
    output logic [LEN_W-1:0]  len,
    output logic              is_zero
);

    always_comb begin
        name    = abi_name(idx, FP_ALIAS);
        len     = abi_len(idx);
        is_zero = (idx == '0);
    end

endmodule

// File: rtl/reg_abi_namer.sv
// Multi-lane RISC-V register ABI namer with one-cycle registered output.
// Ports: clk, reset (sync, high), valid_i, idx_i[5L] -> valid_o,
//        name_o[32L], len_o[3L], is_zero_o[L]; lane k at slice k.
module reg_abi_namer
    import reg_abi_pkg::*;
#(
    parameter int unsigned NUM_LANES = 3,
    parameter bit          FP_ALIAS  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_i,
    input  logic [NUM_LANES*IDX_W-1:0]    idx_i,
    output logic                          valid_o,
    output logic [NUM_LANES*NAME_W-1:0]   name_o,
    output logic [NUM_LANES*LEN_W-1:0]    len_o,
    output logic [NUM_LANES-1:0]          is_zero_o
);

    logic [NUM_LANES*NAME_W-1:0] name_c;
    logic [NUM_LANES*LEN_W-1:0]  len_c;
    logic [NUM_LANES-1:0]        zero_c;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        reg_abi_lut #(
            .FP_ALIAS (FP_ALIAS)
        ) u_lut (
            .idx     (idx_i[k*IDX_W +: IDX_W]),
            .name    (name_c[k*NAME_W +: NAME_W]),
            .len     (len_c[k*LEN_W +: LEN_W]),
            .is_zero (zero_c[k])
        );
    end

    // Data registers only load on a request so the last result stays
    // visible to the disassembler while valid_o is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o   <= 1'b0;
            name_o    <= '0;
            len_o     <= '0;
            is_zero_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                name_o    <= name_c;
                len_o     <= len_c;
                is_zero_o <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_abi_namer.sv
// Randomized self-checking bench for reg_abi_namer against a string model.
// Drives a default and an FP_ALIAS=1 instance with identical stimulus.
module tb_reg_abi_namer;

    localparam int L = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_i = 1'b0;
    logic [L*5-1:0] idx_i = '0;

    logic          valid_o, valid_a;
    logic [L*32-1:0] name_o, name_a;
    logic [L*3-1:0]  len_o, len_a;
    logic [L-1:0]    zero_o, zero_a;

    int checks = 0;
    int failures = 0;

    logic          e_valid;
    logic [L*32-1:0] e_name, e_name_a;
    logic [L*3-1:0]  e_len;
    logic [L-1:0]    e_zero;

    always #5 clk = ~clk;

    reg_abi_namer #(.NUM_LANES(L), .FP_ALIAS(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .idx_i     (idx_i),
        .valid_o   (valid_o),
        .name_o    (name_o),
        .len_o     (len_o),
        .is_zero_o (zero_o)
    );

    reg_abi_namer #(.NUM_LANES(L), .FP_ALIAS(1'b1)) dut_fp (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .idx_i     (idx_i),
        .valid_o   (valid_a),
        .name_o    (name_a),
        .len_o     (len_a),
        .is_zero_o (zero_a)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic string mdl_str(input int i, input bit fp);
        if (i == 0) return "zero";
        if (i == 1) return "ra";
        if (i == 2) return "sp";
        if (i == 3) return "gp";
        if (i == 4) return "tp";
        if (i <= 7) return $sformatf("t%0d", i - 5);
        if (i == 8) return fp ? "fp" : "s0";
        if (i == 9) return "s1";
        if (i <= 17) return $sformatf("a%0d", i - 10);
        if (i <= 27) return $sformatf("s%0d", i - 16);
        return $sformatf("t%0d", i - 25);
    endfunction

    function automatic logic [31:0] pack(input string s);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < s.len(); k++) v = {v[23:0], s[k]};
        return v;
    endfunction

    task automatic step(input logic v, input logic [L*5-1:0] ix,
                        input logic r);
        string s;
        int    n;
        valid_i = v;
        idx_i   = ix;
        reset   = r;
        @(posedge clk);
        if (r) begin
            e_valid = 1'b0;
            e_name = '0;
            e_name_a = '0;
            e_len = '0;
            e_zero = '0;
        end else begin
            e_valid = v;
            if (v) begin
                for (int l = 0; l < L; l++) begin
                    n = int'(ix[l*5 +: 5]);
                    s = mdl_str(n, 1'b0);
                    e_name[l*32 +: 32] = pack(s);
                    e_len[l*3 +: 3] = 3'(s.len());
                    e_zero[l] = (n == 0);
                    e_name_a[l*32 +: 32] = pack(mdl_str(n, 1'b1));
                end
            end
        end
        #1;
        chk("valid", valid_o, e_valid);
        chk("name", name_o, e_name);
        chk("len", len_o, e_len);
        chk("is_zero", zero_o, e_zero);
        chk("fp_valid", valid_a, e_valid);
        chk("fp_name", name_a, e_name_a);
        chk("fp_len", len_a, e_len);
        chk("fp_is_zero", zero_a, e_zero);
    endtask

    function automatic logic [L*5-1:0] rnd_idx();
        return (L*5)'($urandom);
    endfunction

    initial begin
        // reset with an active request: outputs stay cleared
        step(1'b1, {L{5'd31}}, 1'b1);
        step(1'b1, {L{5'd31}}, 1'b1);

        // exhaustive lane-0 sweep, back-to-back
        for (int i = 0; i < 32; i++) begin
            step(1'b1, {rnd_idx() >> 5, 5'(i)}, 1'b0);
            if (i == 0) begin
                chk("x0_lit", name_o[31:0], 32'h7A65726F);
                chk("x0_len", len_o[2:0], 3'd4);
                chk("x0_zero", zero_o[0], 1'b1);
            end
            if (i == 2) chk("x2_lit", name_o[31:0], 32'h00007370);
            if (i == 10) chk("x10_lit", name_o[31:0], 32'h00006130);
            if (i == 27) begin
                chk("x27_lit", name_o[31:0], 32'h00733131);
                chk("x27_len", len_o[2:0], 3'd3);
            end
            if (i == 31) chk("x31_lit", name_o[31:0], 32'h00007436);
        end

        // multi-lane {rs2, rs1, rd}
        step(1'b1, {5'd11, 5'd0, 5'd1}, 1'b0);
        chk("ml_rd", name_o[31:0], 32'h00007261);
        chk("ml_rs1", name_o[63:32], 32'h7A65726F);
        chk("ml_rs1_zero", zero_o[1], 1'b1);
        chk("ml_rs2", name_o[95:64], 32'h00006131);

        // hold: pulse with x8, then idle with changing indices
        step(1'b1, {L{5'd8}}, 1'b0);
        chk("fp_lit", name_a[31:0], 32'h00006670);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, rnd_idx(), 1'b0);
            chk("hold_s0", name_o[31:0], 32'h00007330);
        end
        step(1'b1, {L{5'd9}}, 1'b0);
        chk("fp_s1", name_a[31:0], 32'h00007331);

        // mid-stream reset
        for (int i = 0; i < 4; i++) step(1'b1, rnd_idx(), 1'b0);
        step(1'b1, rnd_idx(), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, rnd_idx(), 1'b0);

        // random traffic with occasional idle and reset
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_idx(),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_abi_namer.md
Name: reg_abi_namer

Overview:
- Translates 5-bit RISC-V integer register indices (x0..x31) into their ABI mnemonic as packed ASCII, e.g. x2 -> "sp", x10 -> "a0".
- Sits beside the instruction decoder/disassembler, which feeds it the rd/rs1/rs2 fields of each instruction and prints the returned names.
- Multiple independent lookup lanes, registered, one-cycle latency.

Parameters:
- NUM_LANES, 3, number of independent index->name lanes (rd, rs1, rs2).
- FP_ALIAS, 0, when 1, x8 is named "fp" instead of "s0".

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  lookup request; all lanes are sampled together.
- idx_i  input  NUM_LANES*5  register indices; lane k occupies bits [5k+4:5k].
- valid_o  output  1  results on name_o/len_o/is_zero_o are valid this cycle.
- name_o  output  NUM_LANES*32  ABI names, lane k at bits [32k+31:32k]; 4 ASCII bytes, right-justified, unused leading bytes 0x00.
- len_o  output  NUM_LANES*3  character count per lane (2..4).
- is_zero_o  output  NUM_LANES  lane index is x0.

Behaviour:
- Mapping table (index -> name):
  - x0 zero; x1 ra; x2 sp; x3 gp; x4 tp.
  - x5..x7 t0..t2.
  - x8 s0 (or fp if FP_ALIAS=1); x9 s1.
  - x10..x17 a0..a7.
  - x18..x27 s2..s11.
  - x28..x31 t3..t6.
- Encoding: first character in the most significant used byte.
  - "zero" = 0x7A65726F.
  - "ra" = 0x00007261.
  - "s11" = 0x00733131.
  - "t6" = 0x00007436.
- len_o:
  - 4 for zero.
  - 3 for s10/s11.
  - 2 for all other names.
- Latency: when valid_i=1 at edge N, lane outputs reflect idx_i sampled at edge N from edge N onward; valid_o=1 for that cycle.
- When valid_i=0 at an edge: valid_o <= 0; name_o/len_o/is_zero_o hold their previous values.
- No backpressure; a new request is accepted every cycle (full throughput).
- Lanes are fully independent. Identical indices on several lanes yield identical outputs.
- All 32 index values are legal; there is no error output.
- Reset (synchronous, wins over valid_i): valid_o=0, name_o=0, len_o=0, is_zero_o=0.
- Reset asserted mid-stream discards the in-flight request. The first valid_i after reset deasserts produces output on the following edge as normal.

Decomposition:
- Package reg_abi_pkg holds:
  - the 32-entry name constant table (32-bit ASCII per entry);
  - the length table;
  - function abi_name(idx, fp_alias).
- Sub-module reg_abi_lut: purely combinational single-lane lookup (idx -> name, len, is_zero). It is instantiated NUM_LANES times under a generate loop; the top adds only the output registers and valid pipeline.

Test Plan:
- Reset: assert reset 2 cycles with valid_i=1, idx=all 5'd31 -> valid_o=0, name_o=0, len_o=0, is_zero_o=0 throughout.
- Exhaustive sweep:
  - Stimulus: lane0 idx 0..31 on consecutive cycles, valid_i=1.
  - Checks one edge later: name matches table, e.g. 0 -> 0x7A65726F (len 4, is_zero 1), 2 -> 0x00007370, 10 -> 0x00006130, 27 -> 0x00733131 (len 3), 31 -> 0x00007436.
  - Checks back-to-back: valid_o stays 1 throughout the sweep.
- Multi-lane: idx {rs2=5'd11, rs1=5'd0, rd=5'd1} -> lane0 "ra", lane1 "zero" with is_zero=1, lane2 "a1".
- Hold: valid pulse with idx 5'd8, then valid_i=0 for 3 cycles with idx changing -> valid_o drops to 0; name stays 0x00007330 ("s0").
- FP_ALIAS=1 instance: idx 8 -> 0x00006670 ("fp"); idx 9 still "s1".
- Mid-stream reset: valid_i=1 continuously; reset pulsed one cycle -> outputs cleared that edge; the next edge resumes correct names.
